// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: control/flag bit positions and the ID/EX payload.
// No logic and no latency; no backpressure.
// Other core files pull these in with import cpu_pkg::*.
package cpu_pkg;

   localparam int DW  = 32;
   localparam int RW  = 5;
   localparam int CW  = 9;
   localparam int FW  = 6;

   // Control bundle bit positions
   localparam int CTRL_MEMTOREG = 8;
   localparam int CTRL_REGWRITE = 7;
   localparam int CTRL_BRANCH   = 6;
   localparam int CTRL_MEMREAD  = 5;
   localparam int CTRL_MEMWRITE = 4;
   localparam int CTRL_REGDST   = 3;
   localparam int CTRL_ALUSRC   = 2;
   localparam int CTRL_ALUOP_HI = 1;
   localparam int CTRL_ALUOP_LO = 0;

   // Instruction-type flag bit positions
   localparam int FLG_BNE  = 5;
   localparam int FLG_BGTZ = 4;
   localparam int FLG_ANDI = 3;
   localparam int FLG_ORI  = 2;
   localparam int FLG_ADDI = 1;
   localparam int FLG_SLTI = 0;

   typedef struct packed {
      logic          valid;
      logic [CW-1:0] ctrl;
      logic [FW-1:0] flags;
      logic [DW-1:0] pc4;
      logic [DW-1:0] rdata1;
      logic [DW-1:0] rdata2;
      logic [DW-1:0] imm;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] rd;
   } idex_t;

   // An instruction reads rt when it is register-sourced, a store, or a bne compare.
   function automatic logic uses_rt(input logic alusrc, input logic memwrite, input logic bne);
      return ~alusrc | memwrite | bne;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction reading the register a load in EX is about to write.
// Purely combinational, zero latency.
// Raises stall toward PC and IF/ID; flush suppresses the load-use stall, mem_wait forces it.
import cpu_pkg::*;

module hazard_detect #(
   parameter int RW = 5
) (
   input  logic          rst_n,
   input  logic          id_valid,
   input  logic          id_alusrc,
   input  logic          id_memwrite,
   input  logic          id_bne,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic          ex_valid,
   input  logic          ex_memread,
   input  logic [RW-1:0] ex_rt,
   input  logic          flush,
   input  logic          mem_wait,
   output logic          load_use,
   output logic          stall
);

   logic id_uses_rt;
   logic rs_match;
   logic rt_match;

   always_comb begin
      id_uses_rt = uses_rt(id_alusrc, id_memwrite, id_bne);
      rs_match   = (ex_rt == id_rs);
      rt_match   = id_uses_rt & (ex_rt == id_rt);
      // A load into $0 produces nothing worth waiting for.
      load_use   = ex_valid & ex_memread & (ex_rt != '0) & id_valid & (rs_match | rt_match);
      stall      = rst_n & (mem_wait | (load_use & ~flush));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch/jump flush and memory-wait hold.
// Latency: 1 cycle from id_* to ex_*; stall is combinational.
// mem_wait freezes every ex_* register; a load-use costs one bubble and raises stall for PC and IF/ID.
import cpu_pkg::*;

module id_ex_stage #(
   parameter int DW   = 32,
   parameter int RW   = 5,
   parameter int CW   = 9,
   parameter int FW   = 6,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [CW-1:0]   id_ctrl,
   input  logic [FW-1:0]   id_flags,
   input  logic [DW-1:0]   id_pc4,
   input  logic [DW-1:0]   id_rdata1,
   input  logic [DW-1:0]   id_rdata2,
   input  logic [DW-1:0]   id_imm,
   input  logic [RW-1:0]   id_rs,
   input  logic [RW-1:0]   id_rt,
   input  logic [RW-1:0]   id_rd,
   input  logic            flush,
   input  logic            mem_wait,
   output logic            ex_valid,
   output logic [CW-1:0]   ex_ctrl,
   output logic [FW-1:0]   ex_flags,
   output logic [DW-1:0]   ex_pc4,
   output logic [DW-1:0]   ex_rdata1,
   output logic [DW-1:0]   ex_rdata2,
   output logic [DW-1:0]   ex_imm,
   output logic [RW-1:0]   ex_rs,
   output logic [RW-1:0]   ex_rt,
   output logic [RW-1:0]   ex_rd,
   output logic            stall,
   output logic [CNTW-1:0] stall_cnt
);

   idex_t           id_p;
   idex_t           ex_q;
   logic            load_use;
   logic [CNTW-1:0] cnt_q;

   hazard_detect #(.RW(RW)) u_hazard (
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_alusrc   (id_ctrl[CTRL_ALUSRC]),
      .id_memwrite (id_ctrl[CTRL_MEMWRITE]),
      .id_bne      (id_flags[FLG_BNE]),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .ex_valid    (ex_q.valid),
      .ex_memread  (ex_q.ctrl[CTRL_MEMREAD]),
      .ex_rt       (ex_q.rt),
      .flush       (flush),
      .mem_wait    (mem_wait),
      .load_use    (load_use),
      .stall       (stall)
   );

   // Control of an empty slot is forced to zero so EX never acts on it.
   always_comb begin
      id_p        = '0;
      id_p.valid  = id_valid;
      id_p.ctrl   = id_valid ? id_ctrl : '0;
      id_p.flags  = id_flags;
      id_p.pc4    = id_pc4;
      id_p.rdata1 = id_rdata1;
      id_p.rdata2 = id_rdata2;
      id_p.imm    = id_imm;
      id_p.rs     = id_rs;
      id_p.rt     = id_rt;
      id_p.rd     = id_rd;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else if (!mem_wait) begin
         if (flush || load_use) begin
            ex_q <= '0;
         end else begin
            ex_q <= id_p;
         end
         if (!flush && load_use && (cnt_q != {CNTW{1'b1}})) begin
            cnt_q <= cnt_q + CNTW'(1);
         end
      end
   end

   always_comb begin
      ex_valid  = ex_q.valid;
      ex_ctrl   = ex_q.ctrl;
      ex_flags  = ex_q.flags;
      ex_pc4    = ex_q.pc4;
      ex_rdata1 = ex_q.rdata1;
      ex_rdata2 = ex_q.rdata2;
      ex_imm    = ex_q.imm;
      ex_rs     = ex_q.rs;
      ex_rt     = ex_q.rt;
      ex_rd     = ex_q.rd;
      stall_cnt = cnt_q;
   end

endmodule
